// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and memory-busy freeze,
// with saturating stall/flush event counters for performance debug.
module hazard_control #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             MemRead_ex,
   input  logic [4:0]       write_register_ex,
   input  logic [4:0]       read_register1_id,
   input  logic [4:0]       read_register2_id,
   input  logic             uses_rs2_id,
   input  logic             branch_taken_mem,
   input  logic             dmem_busy,
   output logic             PC_write,
   output logic             IFID_write,
   output logic             IDEX_bubble,
   output logic             IFID_flush,
   output logic             IDEX_flush,
   output logic             EXMEM_flush,
   output logic             IDEX_write,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam logic [4:0]       XZR     = 5'd31;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LOADUSE = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   state_t state;
   state_t state_next;
   logic   load_use;
   logic   stall_inc;
   logic   flush_inc;

   // XZR is hardwired zero, so a load targeting it never creates a dependency
   assign load_use = MemRead_ex && (write_register_ex != XZR) &&
                     ((write_register_ex == read_register1_id) ||
                      (uses_rs2_id && (write_register_ex == read_register2_id)));

   // Mealy decode: reset, then freeze, then branch flush, then load-use stall
   always_comb begin
      PC_write    = 1'b1;
      IFID_write  = 1'b1;
      IDEX_write  = 1'b1;
      IDEX_bubble = 1'b0;
      IFID_flush  = 1'b0;
      IDEX_flush  = 1'b0;
      EXMEM_flush = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      state_next  = state;

      if (reset) begin
         PC_write   = 1'b0;
         IFID_write = 1'b0;
         state_next = RUN;
      end else if (dmem_busy) begin
         PC_write   = 1'b0;
         IFID_write = 1'b0;
         IDEX_write = 1'b0;
      end else if (branch_taken_mem) begin
         IFID_flush  = 1'b1;
         IDEX_flush  = 1'b1;
         EXMEM_flush = 1'b1;
         flush_inc   = 1'b1;
         state_next  = FLUSH;
      end else if (load_use) begin
         PC_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_bubble = 1'b1;
         stall_inc   = 1'b1;
         state_next  = LOADUSE;
      end else begin
         state_next = RUN;
      end
   end

   // State and saturating event counters
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= RUN;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         state <= state_next;
         if (stall_inc && (stall_cycles != CNT_MAX))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_inc && (flush_events != CNT_MAX))
            flush_events <= flush_events + CNT_W'(1);
      end
   end

endmodule
